deserial_fifo: RTL and testbench

DESERIAL_FIFO -- requirements
Module: deserial_fifo

---
 rtl/serial_pkg.sv | 18 +
 rtl/sync_fifo.sv | 71 +++++++
 rtl/deserial_fifo.sv | 121 ++++++++++++
 tb/tb_deserial_fifo.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Types and constants shared by the serial and deserial blocks.
//   DATA_W     : width of a received/transmitted word
//   MOD_W      : width of the bit-count field (counts 1..DATA_W)
//   ser_word_t : one word as stored in the FIFO, left-aligned data plus count
// -----------------------------------------------------------------------------
package serial_pkg;

  localparam int DATA_W = 16;
  localparam int MOD_W  = 5;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [MOD_W-1:0]  mod;
  } ser_word_t;

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO with a type-parameterised element.
//   clk_i   : clock, all logic on posedge
//   rst_i   : synchronous active-high reset (empties the FIFO)
//   push_i  : write wdata_i; accepted when not full, or when full with a pop
//   wdata_i : element to write
//   pop_i   : remove the head element (ignored when empty)
//   rdata_o : current head element (meaningful only when !empty_o)
//   full_o  : FIFO holds DEPTH elements
//   empty_o : FIFO holds no elements
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     wdata_i,
  input  logic pop_i,
  output T     rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);

  T               mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [AW:0]    cnt_q;
  logic [AW:0]    cnt_d;
  logic           do_push;
  logic           do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a full FIFO can still take a write.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/deserial_fifo.sv
// -----------------------------------------------------------------------------
// deserial_fifo
// Collects serial bits (MSB first) of a busy-delimited frame into a
// left-aligned word and queues {data, bit count} in a FWFT FIFO.
//   clk_i          : clock, all logic on posedge
//   rst_i          : synchronous active-high reset
//   ser_data_i     : serial bit
//   ser_data_val_i : ser_data_i valid this cycle
//   busy_i         : high on every cycle of a frame
//   data_o         : head word, first received bit in [15], unused bits 0
//   data_mod_o     : number of valid bits in data_o (1..16)
//   data_val_o     : head word present
//   data_rdy_i     : consumer takes head when data_val_o && data_rdy_i
//   overflow_o     : pulse, completed word dropped because FIFO was full
//   frame_err_o    : pulse, over-long frame or valid bit outside a frame
// -----------------------------------------------------------------------------
module deserial_fifo
  import serial_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ser_data_i,
  input  logic        ser_data_val_i,
  input  logic        busy_i,
  output logic [15:0] data_o,
  output logic [4:0]  data_mod_o,
  output logic        data_val_o,
  input  logic        data_rdy_i,
  output logic        overflow_o,
  output logic        frame_err_o
);

  localparam int IDX_W = MOD_W - 1;

  logic              busy_q;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [MOD_W-1:0]  cnt_q, cnt_d;
  logic              excess_q, excess_d;
  logic              stray_q;
  logic              ovf_q;

  logic              frame_end;
  logic              capture;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  ser_word_t         wr_word;
  ser_word_t         head;

  assign frame_end = busy_q && !busy_i;
  assign capture   = busy_i && ser_data_val_i;
  assign push      = frame_end && (cnt_q != '0);
  assign pop       = data_val_o && data_rdy_i;

  assign wr_word.data = shift_q;
  assign wr_word.mod  = cnt_q;

  // Bits are placed directly at their final left-aligned position so the
  // unused low bits stay zero without a final alignment shift.
  always_comb begin
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    excess_d = excess_q;
    if (frame_end) begin
      shift_d  = '0;
      cnt_d    = '0;
      excess_d = 1'b0;
    end else if (capture) begin
      if (cnt_q < MOD_W'(DATA_W)) begin
        shift_d[IDX_W'(DATA_W-1) - cnt_q[IDX_W-1:0]] = ser_data_i;
        cnt_d = cnt_q + 1'b1;
      end else begin
        excess_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q   <= 1'b0;
      shift_q  <= '0;
      cnt_q    <= '0;
      excess_q <= 1'b0;
      stray_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      busy_q   <= busy_i;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      excess_q <= excess_d;
      stray_q  <= ser_data_val_i && !busy_i;
      ovf_q    <= push && fifo_full && !pop;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .T     (ser_word_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i (wr_word),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Outputs are forced quiet during reset because the registers behind them
  // only clear on the first reset edge.
  assign data_val_o  = !fifo_empty && !rst_i;
  assign data_o      = data_val_o ? head.data : '0;
  assign data_mod_o  = data_val_o ? head.mod  : '0;
  assign overflow_o  = ovf_q && !rst_i;
  assign frame_err_o = !rst_i && (stray_q || (frame_end && excess_q));

endmodule

// File: tb/tb_deserial_fifo.sv
module tb_deserial_fifo;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        ser_data_i = 1'b0;
  logic        ser_data_val_i = 1'b0;
  logic        busy_i = 1'b0;
  logic [15:0] data_o;
  logic [4:0]  data_mod_o;
  logic        data_val_o;
  logic        data_rdy_i = 1'b0;
  logic        overflow_o;
  logic        frame_err_o;

  int          errors = 0;
  int          checks = 0;
  logic        rdy_v  = 1'b0;

  logic [20:0] got_q [$];
  int          ovf_n  = 0;
  int          ferr_n = 0;

  always #5 clk_i = ~clk_i;

  deserial_fifo #(.DEPTH(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .ser_data_i     (ser_data_i),
    .ser_data_val_i (ser_data_val_i),
    .busy_i         (busy_i),
    .data_o         (data_o),
    .data_mod_o     (data_mod_o),
    .data_val_o     (data_val_o),
    .data_rdy_i     (data_rdy_i),
    .overflow_o     (overflow_o),
    .frame_err_o    (frame_err_o)
  );

  // Observer: records every accepted word and counts pulse cycles.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (data_val_o && data_rdy_i) got_q.push_back({data_o, data_mod_o});
      if (overflow_o)  ovf_n  = ovf_n + 1;
      if (frame_err_o) ferr_n = ferr_n + 1;
    end
  end

  task automatic step(input logic b, input logic v, input logic d);
    @(posedge clk_i); #1;
    busy_i = b; ser_data_val_i = v; ser_data_i = d; data_rdy_i = rdy_v;
    @(negedge clk_i); #1;
  endtask

  task automatic shift_bits(input logic [31:0] vec, input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, vec[31-i]);
  endtask

  task automatic end_frame();
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; busy_i = 1'b1; ser_data_val_i = 1'b1; ser_data_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i); #1;
    checks++; if (data_o !== 16'h0) begin errors++; $display("FAIL rst_data got=%h exp=0000", data_o); end
    checks++; if (data_mod_o !== 5'd0) begin errors++; $display("FAIL rst_mod got=%0d exp=0", data_mod_o); end
    checks++; if (data_val_o !== 1'b0) begin errors++; $display("FAIL rst_val got=%b exp=0", data_val_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%b exp=0", overflow_o); end
    checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL rst_ferr got=%b exp=0", frame_err_o); end
    @(posedge clk_i); #1;
    rst_i = 1'b0; busy_i = 1'b0; ser_data_val_i = 1'b0; ser_data_i = 1'b0;
    @(negedge clk_i); #1;
    checks++; if (data_val_o !== 1'b0) begin errors++; $display("FAIL post_rst_val got=%b exp=0", data_val_o); end
    checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL post_rst_ferr got=%b exp=0", frame_err_o); end
  endtask

  task automatic test_basic();
    int b0, f0;
    rdy_v = 1'b1; b0 = got_q.size(); f0 = ferr_n;
    shift_bits(32'hB000_0000, 4);
    end_frame();
    checks++; if (data_val_o !== 1'b0) begin errors++; $display("FAIL basic_val_at_end got=%b exp=0", data_val_o); end
    step(1'b0, 1'b0, 1'b0);
    checks++; if (data_val_o !== 1'b1) begin errors++; $display("FAIL basic_val got=%b exp=1", data_val_o); end
    checks++; if (data_o !== 16'hB000) begin errors++; $display("FAIL basic_data got=%h exp=b000", data_o); end
    checks++; if (data_mod_o !== 5'd4) begin errors++; $display("FAIL basic_mod got=%0d exp=4", data_mod_o); end
    step(1'b0, 1'b0, 1'b0);
    checks++; if (data_val_o !== 1'b0) begin errors++; $display("FAIL basic_val_after got=%b exp=0", data_val_o); end
    checks++; if (got_q.size() - b0 !== 1) begin errors++; $display("FAIL basic_count got=%0d exp=1", got_q.size() - b0); end
    checks++; if (ferr_n !== f0) begin errors++; $display("FAIL basic_ferr got=%0d exp=%0d", ferr_n, f0); end
  endtask

  task automatic test_back_to_back();
    int b0, f0, o0;
    rdy_v = 1'b1; b0 = got_q.size(); f0 = ferr_n; o0 = ovf_n;
    shift_bits({16'hA5C3, 16'h0000}, 16);
    end_frame();
    shift_bits(32'h8000_0000, 1);
    end_frame();
    idle(2);
    checks++; if (got_q.size() !== b0 + 2) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), b0 + 2); end
    else begin
      checks++; if (got_q[b0] !== {16'hA5C3, 5'd16}) begin errors++; $display("FAIL b2b_word0 got=%h exp=%h", got_q[b0], {16'hA5C3, 5'd16}); end
      checks++; if (got_q[b0+1] !== {16'h8000, 5'd1}) begin errors++; $display("FAIL b2b_word1 got=%h exp=%h", got_q[b0+1], {16'h8000, 5'd1}); end
    end
    checks++; if (ferr_n !== f0) begin errors++; $display("FAIL b2b_ferr got=%0d exp=%0d", ferr_n, f0); end
    checks++; if (ovf_n !== o0) begin errors++; $display("FAIL b2b_ovf got=%0d exp=%0d", ovf_n, o0); end
  endtask

  task automatic test_overflow();
    int b0, o0;
    logic [20:0] exp_w;
    rdy_v = 1'b0; b0 = got_q.size(); o0 = ovf_n;
    for (int k = 0; k < 5; k++) begin
      shift_bits((k % 2 == 0) ? 32'h8000_0000 : 32'h0000_0000, 1);
      end_frame();
    end
    step(1'b0, 1'b0, 1'b0);
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_pulse got=%b exp=1", overflow_o); end
    step(1'b0, 1'b0, 1'b0);
    checks++; if (ovf_n - o0 !== 1) begin errors++; $display("FAIL ovf_cycles got=%0d exp=1", ovf_n - o0); end
    checks++; if (data_val_o !== 1'b1) begin errors++; $display("FAIL ovf_val got=%b exp=1", data_val_o); end
    rdy_v = 1'b1;
    idle(6);
    rdy_v = 1'b0;
    checks++; if (got_q.size() !== b0 + 4) begin errors++; $display("FAIL ovf_drain_count got=%0d exp=%0d", got_q.size(), b0 + 4); end
    else begin
      for (int k = 0; k < 4; k++) begin
        exp_w = (k % 2 == 0) ? {16'h8000, 5'd1} : {16'h0000, 5'd1};
        checks++; if (got_q[b0+k] !== exp_w) begin errors++; $display("FAIL ovf_word%0d got=%h exp=%h", k, got_q[b0+k], exp_w); end
      end
    end
    checks++; if (data_val_o !== 1'b0) begin errors++; $display("FAIL ovf_empty got=%b exp=0", data_val_o); end
  endtask

  task automatic test_full_pop();
    int b0, o0;
    logic [20:0] exp_w [5];
    exp_w[0] = {16'h0000, 5'd2}; exp_w[1] = {16'h4000, 5'd2};
    exp_w[2] = {16'h8000, 5'd2}; exp_w[3] = {16'hC000, 5'd2};
    exp_w[4] = {16'hA000, 5'd3};
    rdy_v = 1'b0; b0 = got_q.size(); o0 = ovf_n;
    for (int k = 0; k < 4; k++) begin
      shift_bits({exp_w[k][20:19], 30'b0}, 2);
      end_frame();
    end
    shift_bits(32'hA000_0000, 3);
    rdy_v = 1'b1;
    end_frame();
    rdy_v = 1'b0;
    idle(1);
    checks++; if (ovf_n !== o0) begin errors++; $display("FAIL fullpop_ovf got=%0d exp=%0d", ovf_n, o0); end
    rdy_v = 1'b1;
    idle(6);
    checks++; if (got_q.size() !== b0 + 5) begin errors++; $display("FAIL fullpop_count got=%0d exp=%0d", got_q.size(), b0 + 5); end
    else begin
      for (int k = 0; k < 5; k++) begin
        checks++; if (got_q[b0+k] !== exp_w[k]) begin errors++; $display("FAIL fullpop_word%0d got=%h exp=%h", k, got_q[b0+k], exp_w[k]); end
      end
    end
  endtask

  task automatic test_long_frame();
    int b0, f0;
    rdy_v = 1'b1; b0 = got_q.size(); f0 = ferr_n;
    shift_bits({16'h9F35, 2'b11, 14'b0}, 18);
    end_frame();
    checks++; if (frame_err_o !== 1'b1) begin errors++; $display("FAIL long_ferr_now got=%b exp=1", frame_err_o); end
    idle(2);
    checks++; if (ferr_n - f0 !== 1) begin errors++; $display("FAIL long_ferr_cycles got=%0d exp=1", ferr_n - f0); end
    checks++; if (got_q.size() !== b0 + 1) begin errors++; $display("FAIL long_count got=%0d exp=%0d", got_q.size(), b0 + 1); end
    else begin
      checks++; if (got_q[b0] !== {16'h9F35, 5'd16}) begin errors++; $display("FAIL long_word got=%h exp=%h", got_q[b0], {16'h9F35, 5'd16}); end
    end
  endtask

  task automatic test_stray_bit();
    int b0, f0;
    rdy_v = 1'b1; b0 = got_q.size(); f0 = ferr_n;
    step(1'b0, 1'b1, 1'b1);
    checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL stray_early got=%b exp=0", frame_err_o); end
    step(1'b0, 1'b0, 1'b0);
    checks++; if (frame_err_o !== 1'b1) begin errors++; $display("FAIL stray_pulse got=%b exp=1", frame_err_o); end
    idle(2);
    checks++; if (ferr_n - f0 !== 1) begin errors++; $display("FAIL stray_cycles got=%0d exp=1", ferr_n - f0); end
    checks++; if (got_q.size() !== b0) begin errors++; $display("FAIL stray_words got=%0d exp=%0d", got_q.size(), b0); end
  endtask

  task automatic test_reset_midframe();
    int b0, f0;
    rdy_v = 1'b1; b0 = got_q.size(); f0 = ferr_n;
    shift_bits(32'hFE00_0000, 7);
    @(posedge clk_i); #1;
    rst_i = 1'b1; busy_i = 1'b1; ser_data_val_i = 1'b0;
    @(negedge clk_i); #1;
    checks++; if (data_val_o !== 1'b0) begin errors++; $display("FAIL midrst_val got=%b exp=0", data_val_o); end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i); #1;
    shift_bits(32'hC000_0000, 3);
    end_frame();
    idle(2);
    checks++; if (got_q.size() !== b0 + 1) begin errors++; $display("FAIL midrst_count got=%0d exp=%0d", got_q.size(), b0 + 1); end
    else begin
      checks++; if (got_q[b0] !== {16'hC000, 5'd3}) begin errors++; $display("FAIL midrst_word got=%h exp=%h", got_q[b0], {16'hC000, 5'd3}); end
    end
    checks++; if (ferr_n !== f0) begin errors++; $display("FAIL midrst_ferr got=%0d exp=%0d", ferr_n, f0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_long_frame();
    test_stray_bit();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
